switch_tx_port: RTL

- Credit-based transmitter that drives one switch input port (the upstream end of the switch ingress link).
- Accepts flits from a local source over a valid/ready interface and emits them as data_ready/flit pulses.
- Keeps per-VC credit counters, replenished by credit-return pulses from the switch's ingress buffers.
- Holds a VC for a whole packet, pulses packet_sent on each tail flit, and reports stalls and credit protocol errors.

---
 rtl/switch_tx_port.sv | 85 ++++++++
 1 files changed

// File: rtl/switch_tx_port.sv
// switch_tx_port: credit-based flit transmitter toward one switch ingress port, with per-VC credits and packet VC locking
package chiplet_types_pkg;
  typedef logic [1:0] vc_t;
  typedef struct packed {
    vc_t vc;
    logic [3:0] src;
  } meta_t;
  typedef struct packed {
    meta_t metadata;
    logic [31:0] payload;
  } flit_t;
endpackage

module switch_tx_port
  import chiplet_types_pkg::*;
#(
  parameter int NUM_VCS = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int STALL_W = 16,
  localparam int CW = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  tx_valid,
  input  flit_t                 tx_flit,
  input  logic                  tx_last,
  output logic                  tx_ready,
  output logic                  data_ready_out,
  output flit_t                 flit_out,
  input  logic [NUM_VCS-1:0]    credit_granted,
  output logic                  packet_sent,
  output logic [NUM_VCS*CW-1:0] credits,
  output logic [STALL_W-1:0]    stall_cycles,
  output logic                  credit_err
);
  typedef enum logic {IDLE, BODY} state_t;
  state_t state, state_next;
  vc_t lock_vc, vc;
  logic [CW-1:0] cnt [NUM_VCS];
  logic [NUM_VCS-1:0] ovf;
  logic accept, has_credit;
  flit_t out_flit;
  always_comb begin
    vc = state == BODY ? lock_vc : tx_flit.metadata.vc;
    has_credit = 1'b0;
    for (int i = 0; i < NUM_VCS; i++)
      if (vc == vc_t'(i) && cnt[i] != '0) has_credit = 1'b1;
    // reset cycle must not accept, so a mid-packet reset drops the flit
    tx_ready = has_credit && !n_rst;
    accept = tx_valid && tx_ready;
    out_flit = tx_flit;
    out_flit.metadata.vc = vc;
    state_next = !accept ? state : tx_last ? IDLE : BODY;
  end
  always_ff @(posedge clk)
    if (n_rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk) begin
    if (n_rst) begin
      data_ready_out <= 1'b0;
      flit_out <= '0;
      packet_sent <= 1'b0;
      stall_cycles <= '0;
      credit_err <= 1'b0;
      lock_vc <= '0;
    end else begin
      data_ready_out <= accept;
      packet_sent <= accept && tx_last;
      if (accept) flit_out <= out_flit;
      if (accept && state == IDLE) lock_vc <= vc;
      if (tx_valid && !tx_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (|ovf) credit_err <= 1'b1;
    end
  end
  genvar v;
  for (v = 0; v < NUM_VCS; v++) begin : g_vc
    logic [CW:0] sum;
    assign sum = {1'b0, cnt[v]} - (CW+1)'(accept && vc == vc_t'(v)) + (CW+1)'(credit_granted[v]);
    assign ovf[v] = sum > (CW+1)'(BUFFER_SIZE);
    assign credits[v*CW +: CW] = cnt[v];
    always_ff @(posedge clk)
      if (n_rst) cnt[v] <= CW'(BUFFER_SIZE);
      else cnt[v] <= ovf[v] ? CW'(BUFFER_SIZE) : sum[CW-1:0];
  end
endmodule
